// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bit positions.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd3,
      OP_INC   = 4'd4,
      OP_DEC   = 4'd5,
      OP_COMP  = 4'd6,
      OP_CHECK = 4'd7,
      OP_LOAD  = 4'd8,
      OP_STORE = 4'd9,
      OP_LI    = 4'd10,
      OP_MUL   = 4'd11,
      OP_SHL   = 4'd12,
      OP_SHR   = 4'd13
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SHL) || (op == OP_SHR);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the decode stage (master) and the ALU (slave).
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] ina;
   logic [WIDTH-1:0] inb;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_hi;
   logic             zf;
   logic             cf;
   logic             nf;

   modport master (
      output in_valid, op, ina, inb, out_ready,
      input  in_ready, out_valid, out, out_hi, zf, cf, nf
   );

   modport slave (
      input  in_valid, op, ina, inb, out_ready,
      output in_ready, out_valid, out, out_hi, zf, cf, nf
   );
endinterface

// File: rtl/alu_seq_iter.sv
// Multi-cycle engine: shift-add multiplier and one-bit-per-cycle logical shifter.
// The first iteration is applied while loading, so done rises after exactly
// WIDTH (MUL) or shamt (SHL/SHR) iterations have been stored.
module alu_seq_iter
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   lo,
   output logic [WIDTH-1:0]   hi,
   output logic               cf,
   output logic               done
);

   logic [3:0]         mode_q, src_mode;
   logic [WIDTH-1:0]   lo_q, hi_q, mcand_q;
   logic [WIDTH-1:0]   src_lo, src_hi, src_m, nxt_lo, nxt_hi;
   logic [WIDTH:0]     sum;
   logic               cf_q, nxt_cf, step, active_q;
   logic [SHAMT_W-1:0] cnt_q;

   // one iteration applied to fresh operands on start, else to the running state
   always_comb begin
      src_mode = start ? mode : mode_q;
      src_m    = start ? a : mcand_q;
      src_hi   = start ? '0 : hi_q;
      src_lo   = start ? ((mode == OP_MUL) ? b : a) : lo_q;
      sum      = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);
      nxt_lo   = src_lo;
      nxt_hi   = src_hi;
      nxt_cf   = cf_q;
      case (src_mode)
         OP_MUL: begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], src_lo[WIDTH-1:1]};
         end
         OP_SHL: begin
            nxt_lo = {src_lo[WIDTH-2:0], 1'b0};
            nxt_cf = src_lo[WIDTH-1];
         end
         OP_SHR: begin
            nxt_lo = {1'b0, src_lo[WIDTH-1:1]};
            nxt_cf = src_lo[0];
         end
         default: ;
      endcase
   end

   assign step = start || (active_q && (cnt_q != '0));

   // datapath registers advance one iteration per cycle while work remains
   always_ff @(posedge clk) begin
      if (step) begin
         lo_q <= nxt_lo;
         hi_q <= nxt_hi;
         cf_q <= nxt_cf;
      end
      if (start) begin
         mode_q  <= mode;
         mcand_q <= a;
      end
   end

   // remaining-iteration counter; reaching zero while active means the result is stored
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else if (start) begin
         active_q <= 1'b1;
         cnt_q    <= (mode == OP_MUL) ? SHAMT_W'(WIDTH - 1) : shamt - SHAMT_W'(1);
      end else if (active_q) begin
         if (cnt_q == '0) active_q <= 1'b0;
         else             cnt_q    <= cnt_q - SHAMT_W'(1);
      end
   end

   assign done = active_q && (cnt_q == '0);
   assign lo   = lo_q;
   assign hi   = hi_q;
   assign cf   = cf_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with IDLE/BUSY/DONE handshake FSM, single-cycle op decode,
// persistent zf/cf/nf flags and an iterative engine for MUL/SHL/SHR.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SUB_ABS = 1,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);

   state_e             state_q, state_d;
   logic [3:0]         op_q;
   logic [SHAMT_W-1:0] shamt;
   logic               accept, iter_start, iter_done, load, zn_upd, lt;
   logic [WIDTH-1:0]   it_lo, it_hi, out_q, hi_q, r_out, r_hi;
   logic               it_cf;
   logic [2:0]         flags_q, r_flags;
   logic [WIDTH:0]     add_w, inc_w;

   function automatic logic [2:0] with_zn(input logic [2:0] f, input logic [WIDTH-1:0] v);
      logic [2:0] r;
      r         = f;
      r[FLAG_Z] = (v == '0);
      r[FLAG_N] = v[WIDTH-1];
      return r;
   endfunction

   assign shamt      = bus.inb[SHAMT_W-1:0];
   assign accept     = (state_q == S_IDLE) && bus.in_valid;
   assign iter_start = accept && ((bus.op == OP_MUL) || (is_shift(bus.op) && (shamt != '0)));
   assign load       = (accept && !iter_start) || ((state_q == S_BUSY) && iter_done);

   alu_seq_iter #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_iter (
      .clk   (clk),
      .rst   (rst),
      .start (iter_start),
      .mode  (bus.op),
      .a     (bus.ina),
      .b     (bus.inb),
      .shamt (shamt),
      .lo    (it_lo),
      .hi    (it_hi),
      .cf    (it_cf),
      .done  (iter_done)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // next state and handshake outputs; requests outside IDLE are ignored
   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = iter_start ? S_BUSY : S_DONE;
         end
         S_BUSY: if (iter_done) state_d = S_DONE;
         S_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // opcode of the in-flight iterative op, needed to interpret the engine result
   always_ff @(posedge clk) begin
      if (accept) op_q <= bus.op;
   end

   // result and flag values to be registered on DONE entry
   always_comb begin
      add_w   = {1'b0, bus.ina} + {1'b0, bus.inb};
      inc_w   = {1'b0, bus.ina} + (WIDTH+1)'(1);
      lt      = bus.ina < bus.inb;
      r_out   = out_q;
      r_hi    = '0;
      r_flags = flags_q;
      zn_upd  = 1'b0;
      if (state_q == S_BUSY) begin
         r_out  = it_lo;
         zn_upd = 1'b1;
         if (op_q == OP_MUL) begin
            r_hi            = it_hi;
            r_flags[FLAG_C] = |it_hi;
         end else begin
            r_flags[FLAG_C] = it_cf;
         end
      end else begin
         case (bus.op)
            OP_AND:  begin r_out = bus.ina & bus.inb; r_flags[FLAG_C] = 1'b0; zn_upd = 1'b1; end
            OP_OR:   begin r_out = bus.ina | bus.inb; r_flags[FLAG_C] = 1'b0; zn_upd = 1'b1; end
            OP_ADD:  begin r_out = add_w[WIDTH-1:0]; r_flags[FLAG_C] = add_w[WIDTH]; zn_upd = 1'b1; end
            OP_SUB: begin
               r_out           = ((SUB_ABS != 0) && lt) ? bus.inb - bus.ina : bus.ina - bus.inb;
               r_flags[FLAG_C] = lt;
               zn_upd          = 1'b1;
            end
            OP_INC:  begin r_out = inc_w[WIDTH-1:0]; r_flags[FLAG_C] = inc_w[WIDTH]; zn_upd = 1'b1; end
            OP_DEC: begin
               r_out           = bus.ina - WIDTH'(1);
               r_flags[FLAG_C] = (bus.ina == '0);
               zn_upd          = 1'b1;
            end
            OP_COMP, OP_CHECK:       r_flags[FLAG_Z] = (bus.ina == bus.inb);
            OP_LOAD, OP_STORE, OP_LI: r_out = bus.ina;
            // only a zero shift amount reaches here; nonzero shifts run on the engine
            OP_SHL, OP_SHR: begin r_out = bus.ina; r_flags[FLAG_C] = 1'b0; zn_upd = 1'b1; end
            default: begin r_out = '0; r_flags = '0; end
         endcase
      end
      if (zn_upd) r_flags = with_zn(r_flags, r_out);
   end

   // result registers and flags change only on DONE entry; reset clears them
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         hi_q    <= '0;
         flags_q <= '0;
      end else if (load) begin
         out_q   <= r_out;
         hi_q    <= r_hi;
         flags_q <= r_flags;
      end
   end

   assign bus.out    = out_q;
   assign bus.out_hi = hi_q;
   assign bus.zf     = flags_q[FLAG_Z];
   assign bus.cf     = flags_q[FLAG_C];
   assign bus.nf     = flags_q[FLAG_N];

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: three instances (8-bit |a-b| SUB, 8-bit wrapping SUB,
// 16-bit) sharing one request driver, checked against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_seq;
   import alu_seq_pkg::*;

   typedef struct packed {
      logic [15:0] out;
      logic [15:0] hi;
      logic        zf;
      logic        cf;
      logic        nf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [3:0]  req_op = 4'd0;
   logic [15:0] req_a = 16'd0, req_b = 16'd0;
   logic        rdy = 1'b1;
   int          sel = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic        o_valid, o_ready;
   res_t        o_res;

   logic [15:0] m_out [3];
   logic        m_zf [3], m_cf [3], m_nf [3];

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(8))  bus_a ();
   alu_seq_if #(.WIDTH(8))  bus_b ();
   alu_seq_if #(.WIDTH(16)) bus_w ();

   alu_seq #(.WIDTH(8),  .SUB_ABS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   alu_seq #(.WIDTH(8),  .SUB_ABS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
   alu_seq #(.WIDTH(16), .SUB_ABS(1)) dut_w (.clk(clk), .rst(rst), .bus(bus_w.slave));

   assign bus_a.in_valid  = req_valid && (sel == 0);
   assign bus_a.op        = req_op;
   assign bus_a.ina       = req_a[7:0];
   assign bus_a.inb       = req_b[7:0];
   assign bus_a.out_ready = rdy;
   assign bus_b.in_valid  = req_valid && (sel == 1);
   assign bus_b.op        = req_op;
   assign bus_b.ina       = req_a[7:0];
   assign bus_b.inb       = req_b[7:0];
   assign bus_b.out_ready = rdy;
   assign bus_w.in_valid  = req_valid && (sel == 2);
   assign bus_w.op        = req_op;
   assign bus_w.ina       = req_a;
   assign bus_w.inb       = req_b;
   assign bus_w.out_ready = rdy;

   always_comb begin
      case (sel)
         1: begin
            o_valid = bus_b.out_valid;
            o_ready = bus_b.in_ready;
            o_res   = {8'h00, bus_b.out, 8'h00, bus_b.out_hi, bus_b.zf, bus_b.cf, bus_b.nf};
         end
         2: begin
            o_valid = bus_w.out_valid;
            o_ready = bus_w.in_ready;
            o_res   = {bus_w.out, bus_w.out_hi, bus_w.zf, bus_w.cf, bus_w.nf};
         end
         default: begin
            o_valid = bus_a.out_valid;
            o_ready = bus_a.in_ready;
            o_res   = {8'h00, bus_a.out, 8'h00, bus_a.out_hi, bus_a.zf, bus_a.cf, bus_a.nf};
         end
      endcase
   end

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_out[i] = 16'd0;
         m_zf[i]  = 1'b0;
         m_cf[i]  = 1'b0;
         m_nf[i]  = 1'b0;
      end
   endtask

   // Reference: result, flags and latency from plain arithmetic for the selected instance.
   task automatic model(input logic [3:0] op, input logic [15:0] a16, input logic [15:0] b16,
                        output res_t e, output int lat);
      int              w, s;
      bit              sabs, zn;
      longint unsigned a, b, mask, r, hi;
      logic            z, c, n;
      w    = (sel == 2) ? 16 : 8;
      sabs = (sel != 1);
      mask = (64'd1 << w) - 64'd1;
      a    = {48'd0, a16} & mask;
      b    = {48'd0, b16} & mask;
      r    = {48'd0, m_out[sel]};
      hi   = 0;
      z    = m_zf[sel];
      c    = m_cf[sel];
      n    = m_nf[sel];
      zn   = 1'b1;
      lat  = 1;
      s    = int'(b % longint'(w));
      case (op)
         4'd0: begin r = a & b; c = 1'b0; end
         4'd1: begin r = a | b; c = 1'b0; end
         4'd2: begin r = a + b; c = (r > mask); r = r & mask; end
         4'd3: begin c = (a < b); r = (sabs && a < b) ? b - a : (a - b) & mask; end
         4'd4: begin r = a + 1; c = (r > mask); r = r & mask; end
         4'd5: begin c = (a == 0); r = (a - 1) & mask; end
         4'd6, 4'd7: begin z = (a == b); zn = 1'b0; end
         4'd8, 4'd9, 4'd10: begin r = a; zn = 1'b0; end
         4'd11: begin r = (a * b) & mask; hi = (a * b) >> w; c = (hi != 0); lat = w + 1; end
         4'd12: begin r = (a << s) & mask; c = (s == 0) ? 1'b0 : a[w-s]; lat = s + 1; end
         4'd13: begin r = a >> s; c = (s == 0) ? 1'b0 : a[s-1]; lat = s + 1; end
         default: begin r = 0; z = 1'b0; c = 1'b0; n = 1'b0; zn = 1'b0; end
      endcase
      if (zn) begin
         z = (r == 0);
         n = r[w-1];
      end
      m_out[sel] = r[15:0];
      m_zf[sel]  = z;
      m_cf[sel]  = c;
      m_nf[sel]  = n;
      e.out = r[15:0];
      e.hi  = hi[15:0];
      e.zf  = z;
      e.cf  = c;
      e.nf  = n;
   endtask

   // Drives one request and collects the response; requests are fired while busy
   // to show they are ignored. lat=-1 means the response never arrived.
   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold, output int lat, output res_t r,
                         output int busy_rdy, output int unstable);
      int guard;
      lat = -1; r = '0; busy_rdy = 0; unstable = 0; guard = 0;
      @(negedge clk);
      while (!o_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!o_ready) return;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      rdy = (hold == 0);
      @(negedge clk);
      lat = 1;
      while (!o_valid && lat < 100) begin
         if (o_ready) busy_rdy++;
         req_valid = 1'b1;
         req_op    = 4'($urandom_range(0, 15));
         req_a     = 16'($urandom);
         req_b     = 16'($urandom);
         @(negedge clk);
         lat++;
      end
      req_valid = 1'b0;
      if (!o_valid) begin
         lat = -1;
         return;
      end
      if (o_ready) busy_rdy++;
      r = o_res;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!o_valid || o_ready || o_res !== r) unstable++;
      end
      rdy = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; rdy = 1'b1;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_checks++;
         if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_res !== '0) begin
            n_fail++;
            $display("FAIL reset sel%0d: got ready=%b valid=%b res=%h, expected ready=1 valid=0 res=0",
                     s, o_ready, o_valid, o_res);
         end
      end
      rst = 1'b0;
      model_reset();
      sel = 0;
   endtask

   // ADD carry, SUB in both modes: table of {sel, op, a, b}
   task automatic test_arith();
      int   t_sel [3] = '{0, 0, 1};
      int   t_op  [3] = '{2, 3, 3};
      int   t_a   [3] = '{'hF0, 3, 3};
      int   t_b   [3] = '{'h20, 5, 5};
      res_t e, r;
      int   elat, lat, br, us;
      for (int i = 0; i < 3; i++) begin
         sel = t_sel[i];
         model(4'(t_op[i]), 16'(t_a[i]), 16'(t_b[i]), e, elat);
         run_op(4'(t_op[i]), 16'(t_a[i]), 16'(t_b[i]), 0, lat, r, br, us);
         n_checks++;
         if (r !== e || lat != elat) begin
            n_fail++;
            $display("FAIL arith%0d: got res=%h lat=%0d, expected res=%h lat=%0d", i, r, lat, e, elat);
         end
      end
      n_checks++;
      if (r.out !== 16'h00FE || r.nf !== 1'b1 || r.cf !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_wrap: got out=%h nf=%b cf=%b, expected out=00fe nf=1 cf=1", r.out, r.nf, r.cf);
      end
   endtask

   task automatic test_mul();
      res_t e, r;
      int   elat, lat, br, us;
      sel = 0;
      model(4'd11, 16'h0010, 16'h0020, e, elat);
      run_op(4'd11, 16'h0010, 16'h0020, 0, lat, r, br, us);
      n_checks++;
      if (r !== e || lat != 9) begin
         n_fail++;
         $display("FAIL mul8: got res=%h lat=%0d, expected res=%h lat=9", r, lat, e);
      end
      n_checks++;
      if (br != 0) begin
         n_fail++;
         $display("FAIL mul8_ready: got %0d cycles with in_ready=1 while busy, expected 0", br);
      end
      sel = 2;
      model(4'd11, 16'hFFFF, 16'hFFFF, e, elat);
      run_op(4'd11, 16'hFFFF, 16'hFFFF, 0, lat, r, br, us);
      n_checks++;
      if (r.out !== 16'h0001 || r.hi !== 16'hFFFE || r !== e || lat != 17) begin
         n_fail++;
         $display("FAIL mul16: got res=%h lat=%0d, expected res=%h lat=17", r, lat, e);
      end
      sel = 0;
   endtask

   task automatic test_shift_comp();
      int   t_op [3] = '{13, 6, 12};
      int   t_a  [3] = '{'h81, 'h55, 'h3C};
      int   t_b  [3] = '{3, 'h55, 0};
      int   t_lat[3] = '{4, 1, 1};
      res_t e, r;
      int   elat, lat, br, us;
      sel = 0;
      for (int i = 0; i < 3; i++) begin
         model(4'(t_op[i]), 16'(t_a[i]), 16'(t_b[i]), e, elat);
         run_op(4'(t_op[i]), 16'(t_a[i]), 16'(t_b[i]), 0, lat, r, br, us);
         n_checks++;
         if (r !== e || lat != t_lat[i] || elat != t_lat[i]) begin
            n_fail++;
            $display("FAIL shift_comp%0d: got res=%h lat=%0d, expected res=%h lat=%0d",
                     i, r, lat, e, t_lat[i]);
         end
         if (i == 1) begin
            n_checks++;
            if (r.out !== 16'h0010 || r.zf !== 1'b1 || r.cf !== 1'b0) begin
               n_fail++;
               $display("FAIL comp_keep: got out=%h zf=%b cf=%b, expected out=0010 zf=1 cf=0",
                        r.out, r.zf, r.cf);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      res_t e, r;
      int   elat, lat, br, us;
      sel = 0;
      model(4'd4, 16'h00FF, 16'h0000, e, elat);
      run_op(4'd4, 16'h00FF, 16'h0000, 5, lat, r, br, us);
      n_checks++;
      if (r !== e || r.out !== 16'h0000 || r.zf !== 1'b1 || r.cf !== 1'b1 || lat != 1) begin
         n_fail++;
         $display("FAIL inc_hold: got res=%h lat=%0d, expected res=%h lat=1", r, lat, e);
      end
      n_checks++;
      if (us != 0 || br != 0) begin
         n_fail++;
         $display("FAIL hold_stable: got %0d unstable cycles and %0d ready cycles, expected 0 and 0", us, br);
      end
   endtask

   task automatic test_reset_mid();
      int guard, seen;
      sel = 0; guard = 0; seen = 0;
      @(negedge clk);
      while (!o_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b1; req_op = 4'd11; req_a = 16'h00A5; req_b = 16'h00C3;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_res !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: got ready=%b valid=%b res=%h, expected ready=1 valid=0 res=0",
                  o_ready, o_valid, o_res);
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (o_valid) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL reset_abort: got %0d cycles of out_valid after reset, expected 0", seen);
      end
   endtask

   task automatic test_random();
      res_t        e, r;
      int          elat, lat, br, us, hold;
      logic [3:0]  op;
      logic [15:0] a, b, mask;
      for (int s = 0; s < 3; s++) begin
         sel  = s;
         mask = (s == 2) ? 16'hFFFF : 16'h00FF;
         for (int i = 0; i < 40; i++) begin
            op   = 4'($urandom_range(0, 15));
            a    = 16'($urandom) & mask;
            b    = 16'($urandom) & mask;
            if (i % 5 == 0) b = a;
            hold = $urandom_range(0, 2);
            model(op, a, b, e, elat);
            run_op(op, a, b, hold, lat, r, br, us);
            n_checks++;
            if (r !== e || lat != elat) begin
               n_fail++;
               $display("FAIL rand sel%0d op%0d a=%h b=%h: got res=%h lat=%0d, expected res=%h lat=%0d",
                        s, op, a, b, r, lat, e, elat);
            end
            n_checks++;
            if (br != 0 || us != 0) begin
               n_fail++;
               $display("FAIL rand_hs sel%0d op%0d: got ready_busy=%0d unstable=%0d, expected 0 and 0",
                        s, op, br, us);
            end
         end
      end
      sel = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_arith();
      test_mul();
      test_shift_comp();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not complete, n_checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational datapath ALU.
- Performs the existing op set (AND, OR, ADD, SUB, INC, DEC, COMP, CHECK, LOAD, STORE, LI) at WIDTH bits.
- Adds iterative multi-cycle MUL, SHL and SHR, a persistent flag register (zf, cf, nf) and valid/ready handshakes on both sides.
- Sits between the decode/register-file stage and writeback in the multi-cycle CPU.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2, power of two).
- SUB_ABS, 1, 1 = SUB returns |ina-inb| (legacy behaviour); 0 = two's-complement ina-inb.
- SHAMT_W, $clog2(WIDTH), width of the shift amount taken from inb[SHAMT_W-1:0].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  ALU can accept a request
- op  in  4  opcode
- ina  in  WIDTH  operand A
- inb  in  WIDTH  operand B / shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result (low half for MUL)
- out_hi  out  WIDTH  high half of MUL product; 0 for all other ops
- zf  out  1  zero flag (registered, persistent)
- cf  out  1  carry/borrow flag (registered, persistent)
- nf  out  1  negative flag = MSB of result (registered, persistent)

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, out_hi=0, zf=0, cf=0, nf=0. Reset mid-operation aborts it; no result is emitted.
- Opcodes (shared constants): AND=0, OR=1, ADD=2, SUB=3, INC=4, DEC=5, COMP=6, CHECK=7, LOAD=8, STORE=9, LI=10, MUL=11, SHL=12, SHR=13. Codes 14-15 give out=0 and flags cleared.
- FSM IDLE -> BUSY -> DONE:
  - IDLE: in_ready=1. Accept when in_valid; capture op, ina, inb.
  - Single-cycle ops: go IDLE->DONE, so the result is visible with out_valid=1 on the cycle after acceptance (latency 1).
  - MUL: shift-add, one bit per cycle. BUSY for exactly WIDTH cycles, then DONE (latency WIDTH+1).
  - SHL/SHR: logical, one position per cycle. Shift amount s = inb[SHAMT_W-1:0]. BUSY for s cycles, then DONE; s=0 goes directly to DONE (latency s+1).
  - DONE: out_valid=1; out, out_hi and flags stable. On out_ready, go to IDLE next cycle.
  - in_ready=0 in BUSY and DONE. in_valid there is ignored, not queued.
- Arithmetic, all results mod 2^WIDTH:
  - ADD: cf = carry out.
  - INC: cf = carry out.
  - DEC: cf = borrow (ina==0).
  - SUB, SUB_ABS=0: out = ina-inb; cf = (ina<inb).
  - SUB, SUB_ABS=1: out = |ina-inb|; cf = (ina<inb).
  - MUL: {out_hi,out} = ina*inb unsigned; cf = (out_hi!=0).
  - SHL/SHR: cf = last bit shifted out (0 if s=0).
- Flag updates happen on the DONE entry cycle:
  - AND, OR, ADD, SUB, INC, DEC, MUL, SHL, SHR: zf = (out==0), nf = out[WIDTH-1].
  - AND, OR: cf = 0.
  - COMP, CHECK: zf = (ina==inb); out keeps its previous value; cf and nf unchanged.
  - LOAD, STORE, LI: out = ina; all flags unchanged.
- Flags persist across transactions until the next updating op or reset.
- Backpressure: holding out_ready low keeps DONE, out and flags indefinitely.

Decomposition:
- Opcode constants, state encoding and flag-index constants go in the shared definitions header, extending the existing opcode set with MUL, SHL and SHR.
- One sub-module, alu_seq_iter: the multi-cycle engine (shift-add multiplier plus shifter, with a cycle counter and done pulse). The top holds the FSM, single-cycle ops, flags and handshake.

Test Plan (WIDTH=8 unless noted):
- Reset then ADD: ina=0xF0, inb=0x20, in_valid 1 cycle -> next cycle out_valid=1, out=0x10, cf=1, zf=0, nf=0.
- SUB with SUB_ABS=1: ina=3, inb=5 -> out=2, cf=1. With SUB_ABS=0, same inputs -> out=0xFE, nf=1, cf=1.
- MUL: ina=0x10, inb=0x20 -> out_valid exactly 9 cycles after accept; out=0x00, out_hi=0x02, zf=1, cf=1. in_ready=0 and a second in_valid ignored throughout.
- SHR then COMP: SHR ina=0x81, inb=3 -> out_valid after 4 cycles, out=0x10, cf=0. Then COMP ina=inb=0x55 -> zf=1, out stays 0x10, cf unchanged. SHL with inb=0 -> latency 1, out=ina.
- Backpressure/reset: INC 0xFF with out_ready=0 for 5 cycles -> out=0x00, zf=1, cf=1 held stable. Start a MUL, assert rst in cycle 3 -> next cycle all outputs at reset values, in_ready=1, no out_valid.
- WIDTH=16 regression: MUL ina=0xFFFF, inb=0xFFFF -> out=0x0001, out_hi=0xFFFE, latency 17.
